// File: rtl/button_poll_master.sv
// Avalon-MM polling master: periodically reads a 4-bit button word, debounces it,
// and reports committed level changes through a valid/ready event channel.
module button_poll_master #(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [3:0]  btn_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_changed,
  output logic [3:0]  evt_state,
  output logic        evt_overflow
);

  localparam int TMR_W = (POLL_DIV > 4) ? $clog2(POLL_DIV) : 2;
  localparam logic [TMR_W-1:0] TMR_START  = TMR_W'(POLL_DIV - 1);
  // REQ, LAT and CAP each take one cycle, so the reload shortens IDLE by three
  // to keep an unstalled poll period of exactly POLL_DIV cycles.
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_DIV - 4);
  localparam logic [3:0]       DEB_MAX    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAT  = 2'd2,
    CAP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [3:0]        rdata_q, rdata_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        btn_q, btn_d;
  logic              evt_valid_q, evt_valid_d;
  logic [3:0]        evt_changed_q, evt_changed_d;
  logic [3:0]        evt_state_q, evt_state_d;
  logic              evt_ovf_q, evt_ovf_d;

  logic [3:0]        sample;
  logic              commit;
  logic              xfer;
  logic              unused_rdata;

  assign unused_rdata = ^avm_readdata[31:4];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (timer_q == '0) state_d = REQ;
      REQ:  if (!avm_waitrequest) state_d = LAT;
      LAT:  state_d = CAP;
      CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs
  always_comb begin
    avm_read    = (state_q == REQ);
    avm_address = 2'd0;
  end

  // Poll timer only runs in IDLE
  always_comb begin
    timer_d = timer_q;
    case (state_q)
      IDLE:    if (timer_q != '0) timer_d = timer_q - 1'b1;
      CAP:     timer_d = TMR_RELOAD;
      default: timer_d = timer_q;
    endcase
  end

  // Read data is only valid during LAT; hold it for CAP
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == LAT) rdata_d = avm_readdata[3:0];
  end

  assign sample = (ACTIVE_LOW != 0) ? ~rdata_q : rdata_q;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    btn_d  = btn_q;
    commit = 1'b0;
    if (state_q == CAP) begin
      if (sample == cand_q) begin
        if (cnt_q < DEB_MAX) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = sample;
        cnt_d  = 4'd1;
      end
      if ((cnt_d == DEB_MAX) && (cand_d != btn_q)) begin
        commit = 1'b1;
        btn_d  = cand_d;
      end
    end
  end

  // A commit while an event is still pending (and not leaving this cycle) merges
  // into it and flags the loss of the intermediate state.
  always_comb begin
    xfer          = evt_valid_q & evt_ready;
    evt_valid_d   = evt_valid_q;
    evt_changed_d = evt_changed_q;
    evt_state_d   = evt_state_q;
    evt_ovf_d     = evt_ovf_q;
    if (commit) begin
      evt_state_d = btn_d;
      if (evt_valid_q && !xfer) begin
        evt_changed_d = evt_changed_q | (btn_q ^ btn_d);
        evt_ovf_d     = 1'b1;
      end else begin
        evt_valid_d   = 1'b1;
        evt_changed_d = btn_q ^ btn_d;
        evt_ovf_d     = 1'b0;
      end
    end else if (xfer) begin
      evt_valid_d   = 1'b0;
      evt_changed_d = 4'd0;
      evt_ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q       <= TMR_START;
      rdata_q       <= 4'd0;
      cand_q        <= 4'd0;
      cnt_q         <= 4'd0;
      btn_q         <= 4'd0;
      evt_valid_q   <= 1'b0;
      evt_changed_q <= 4'd0;
      evt_state_q   <= 4'd0;
      evt_ovf_q     <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      rdata_q       <= rdata_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      btn_q         <= btn_d;
      evt_valid_q   <= evt_valid_d;
      evt_changed_q <= evt_changed_d;
      evt_state_q   <= evt_state_d;
      evt_ovf_q     <= evt_ovf_d;
    end
  end

  assign btn_state    = btn_q;
  assign evt_valid    = evt_valid_q;
  assign evt_changed  = evt_changed_q;
  assign evt_state    = evt_state_q;
  assign evt_overflow = evt_ovf_q;

endmodule

// File: tb/tb_button_poll_master.sv
// Bench for button_poll_master: Avalon slave model with stalls, debounce/event
// reference model feeding scoreboard queues, and an independent output monitor.
module tb_button_poll_master;

  localparam int POLL_DIV   = 8;
  localparam int DEBOUNCE   = 2;
  localparam int ACTIVE_LOW = 1;

  logic        clk;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [3:0]  btn_state;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_changed;
  logic [3:0]  evt_state;
  logic        evt_overflow;

  button_poll_master #(
    .POLL_DIV  (POLL_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .btn_state      (btn_state),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_changed    (evt_changed),
    .evt_state      (evt_state),
    .evt_overflow   (evt_overflow)
  );

  typedef struct { logic [3:0] raw; int stall; } poll_t;
  typedef struct { logic [3:0] val; int cyc; } btn_exp_t;
  typedef struct { int cyc; logic [3:0] old_v; logic [3:0] new_v; } cap_t;
  typedef struct { logic [3:0] changed; logic [3:0] state; logic ovf; } evt_t;

  poll_t    poll_q[$];
  btn_exp_t btn_q[$];
  cap_t     cap_q[$];
  evt_t     evt_q[$];
  logic [3:0] hist[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   rdy_mode = 0;
  logic force_wait = 1'b0;
  logic in_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave + reference model: bus timing, debounce and event merging from the rules
  initial begin
    logic       rst_seen;
    logic       xfer, m_pend, m_ovf, exp_rd;
    logic [3:0] m_btn, m_changed, m_state, last_raw, s;
    int         exp_start, stall_left, run;
    poll_t      cur;
    cap_t       it;
    rst_seen = 1'b1; m_pend = 1'b0; m_ovf = 1'b0; m_btn = 4'd0;
    m_changed = 4'd0; m_state = 4'd0; last_raw = 4'hF;
    exp_start = 0; stall_left = 0; cur = '{4'hF, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        rst_seen = 1'b1; in_req = 1'b0; stall_left = 0;
        cap_q.delete(); hist.delete();
        m_btn = 4'd0; m_pend = 1'b0; m_changed = 4'd0; m_state = 4'd0; m_ovf = 1'b0;
        avm_waitrequest = force_wait;
        evt_ready = 1'b0;
        continue;
      end
      if (rst_seen) begin
        rst_seen  = 1'b0;
        exp_start = cyc + POLL_DIV;
      end
      case (rdy_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = ($urandom_range(0, 2) == 0);
      endcase
      xfer = m_pend && evt_ready;
      if (xfer) evt_q.push_back('{m_changed, m_state, m_ovf});
      if (cap_q.size() > 0 && cap_q[0].cyc == cyc) begin
        it = cap_q.pop_front();
        if (m_pend && !xfer) begin
          m_changed = m_changed | (it.old_v ^ it.new_v);
          m_ovf     = 1'b1;
        end else begin
          m_changed = it.old_v ^ it.new_v;
          m_ovf     = 1'b0;
        end
        m_pend  = 1'b1;
        m_state = it.new_v;
      end else if (xfer) begin
        m_pend = 1'b0; m_changed = 4'd0; m_ovf = 1'b0;
      end
      exp_rd = in_req || (cyc == exp_start);
      check("avm_read", avm_read, exp_rd);
      avm_waitrequest = 1'b0;
      if (exp_rd) begin
        if (!in_req) begin
          check("avm_address", avm_address, 0);
          in_req = 1'b1;
          if (poll_q.size() > 0) cur = poll_q.pop_front();
          else cur = '{last_raw, 0};
          stall_left = cur.stall;
        end
        if (force_wait || stall_left > 0) begin
          avm_waitrequest = 1'b1;
          if (stall_left > 0) stall_left--;
        end else begin
          in_req    = 1'b0;
          n_acc++;
          exp_start = cyc + POLL_DIV;
          last_raw  = cur.raw;
          avm_readdata = {28'($urandom), cur.raw};
          s = (ACTIVE_LOW != 0) ? ~cur.raw : cur.raw;
          hist.push_back(s);
          if (hist.size() > 16) void'(hist.pop_front());
          run = 0;
          for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != s) break;
            run++;
          end
          if (run >= DEBOUNCE && s != m_btn) begin
            cap_q.push_back('{cyc + 2, m_btn, s});
            btn_q.push_back('{s, cyc + 3});
            m_btn = s;
          end
        end
      end
    end
  end

  // Monitor: compares every observed output change/transfer against the queues
  initial begin
    logic       rst_prev;
    logic [3:0] last_btn;
    btn_exp_t   b;
    evt_t       e;
    rst_prev = 1'b1;
    last_btn = 4'd0;
    forever begin
      @(negedge clk);
      #1;
      if (reset || rst_prev) begin
        last_btn = btn_state;
        rst_prev = reset;
        continue;
      end
      rst_prev = reset;
      if (btn_state !== last_btn) begin
        if (btn_q.size() == 0) begin
          check("btn_unexpected_change", btn_state, last_btn);
        end else begin
          b = btn_q.pop_front();
          check("btn_state_value", btn_state, b.val);
          check("btn_state_cycle", cyc, b.cyc);
        end
        last_btn = btn_state;
      end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (evt_q.size() == 0) begin
          check("evt_unexpected_valid", evt_valid, 0);
        end else begin
          e = evt_q.pop_front();
          check("evt_changed", evt_changed, e.changed);
          check("evt_state", evt_state, e.state);
          check("evt_overflow", evt_overflow, e.ovf);
        end
      end
    end
  end

  task automatic push_poll(input logic [3:0] raw, input int stall);
    poll_q.push_back('{raw, stall});
  endtask

  task automatic wait_polls(input int extra);
    int guard;
    guard = 0;
    while ((poll_q.size() > 0 || in_req) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 3000) check("poll_progress_timeout", guard, 0);
    repeat (extra) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rnd_raw;
    int guard;
    reset = 1'b1; avm_waitrequest = 1'b0; avm_readdata = 32'hF; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_btn_state", btn_state, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_changed", evt_changed, 0);
    check("rst_evt_state", evt_state, 0);
    check("rst_evt_overflow", evt_overflow, 0);
    reset = 1'b0;

    // Released buttons: regular polls, nothing commits
    rdy_mode = 2;
    repeat (6) push_poll(4'hF, 0);
    wait_polls(4);
    check("idle_btn_state", btn_state, 0);
    check("idle_evt_valid", evt_valid, 0);

    // Single-poll glitch is filtered
    push_poll(4'hE, 0);
    repeat (3) push_poll(4'hF, 0);
    wait_polls(4);
    check("glitch_btn_state", btn_state, 0);
    check("glitch_evt_valid", evt_valid, 0);

    // Two identical presses commit bit 0
    rdy_mode = 0;
    push_poll(4'hE, 0);
    push_poll(4'hE, 0);
    wait_polls(4);
    check("press_btn_state", btn_state, 4'h1);
    check("press_evt_valid", evt_valid, 1);
    check("press_evt_changed", evt_changed, 4'h1);
    check("press_evt_state", evt_state, 4'h1);
    check("press_evt_overflow", evt_overflow, 0);

    // Long stall, then release
    rdy_mode = 1;
    push_poll(4'hE, 5);
    push_poll(4'hF, 0);
    push_poll(4'hF, 0);
    wait_polls(4);
    check("release_btn_state", btn_state, 0);
    check("release_evt_valid", evt_valid, 0);

    // Two commits while the consumer stalls merge into one event
    rdy_mode = 0;
    push_poll(4'hE, 0);
    push_poll(4'hE, 0);
    push_poll(4'hC, 0);
    push_poll(4'hC, 0);
    wait_polls(4);
    check("merge_evt_valid", evt_valid, 1);
    check("merge_evt_changed", evt_changed, 4'h3);
    check("merge_evt_state", evt_state, 4'h3);
    check("merge_evt_overflow", evt_overflow, 1);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    check("accept_evt_valid", evt_valid, 0);
    check("accept_evt_changed", evt_changed, 0);
    check("accept_evt_overflow", evt_overflow, 0);

    // Random buttons, stalls and consumer backpressure
    rdy_mode = 2;
    rnd_raw = 4'hC;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) rnd_raw = 4'($urandom_range(0, 15));
      push_poll(rnd_raw, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end
    wait_polls(4);
    rdy_mode = 1;
    repeat (3 * POLL_DIV + 8) @(posedge clk);
    #1;
    check("drain_btn_queue", btn_q.size(), 0);
    check("drain_evt_queue", evt_q.size(), 0);

    // Reset during a stalled request
    force_wait = 1'b1;
    guard = 0;
    while (avm_read !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("stalled_req_seen", avm_read, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_avm_read", avm_read, 0);
    check("midrst_btn_state", btn_state, 0);
    check("midrst_evt_valid", evt_valid, 0);
    check("midrst_evt_changed", evt_changed, 0);
    check("midrst_evt_state", evt_state, 0);
    check("midrst_evt_overflow", evt_overflow, 0);
    reset = 1'b0;
    force_wait = 1'b0;
    push_poll(4'hF, 0);
    push_poll(4'hF, 0);
    wait_polls(4);

    check("final_btn_queue", btn_q.size(), 0);
    check("final_evt_queue", evt_q.size(), 0);
    check("accepted_reads_min", (n_acc >= 81) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
